// File: rtl/dsp_fir_stream_engine.sv
// Streaming signed FIR/MAC engine: one MAC per cycle over TAPS taps, with a
// runtime-loadable coefficient bank, bypass mode, round/saturate, and statistics counters.
module dsp_fir_stream_engine #(
  parameter int DATA_W  = 8,
  parameter int COEFF_W = 8,
  parameter int TAPS    = 16,
  parameter int SHIFT   = 0,
  parameter int ACC_W   = DATA_W + COEFF_W + $clog2(TAPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      flush,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEFF_W-1:0] coef_data,
  output logic                      coef_err,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [DATA_W-1:0]  s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [DATA_W-1:0]  m_data,
  output logic                      m_sat,
  output logic                      busy,
  output logic [31:0]               sample_count,
  output logic [31:0]               sat_count
);
  // state | meaning
  // IDLE  | ready for a sample, coefficient writes and flush
  // MAC   | one tap per cycle, final result registered on the last tap
  // OUT   | result held on m_data until m_ready
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  localparam int TW = $clog2(TAPS);
  localparam logic [TW-1:0] LAST_TAP = TW'(TAPS - 1);
  localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W:0] MIN_V = (ACC_W+1)'(-(1 << (DATA_W-1)));

  state_t state, state_nx;
  logic signed [DATA_W-1:0]  delay [TAPS];
  logic signed [COEFF_W-1:0] coeff [TAPS];
  logic signed [ACC_W-1:0]   acc, d_ext, c_ext, prod, acc_sum;
  logic signed [ACC_W:0]     rnd, shr;
  logic signed [DATA_W-1:0]  res_data;
  logic                      res_sat;
  logic [TW-1:0]             tap;
  logic                      accept;

  assign s_ready = (state == IDLE) && !rst;
  assign accept  = s_valid && s_ready;
  assign m_valid = (state == OUT);
  assign busy    = (state != IDLE);

  // The last tap's product is folded in combinationally so the result
  // register loads on the same edge that closes the MAC phase.
  always_comb begin
    d_ext    = {{(ACC_W-DATA_W){delay[tap][DATA_W-1]}}, delay[tap]};
    c_ext    = {{(ACC_W-COEFF_W){coeff[tap][COEFF_W-1]}}, coeff[tap]};
    prod     = d_ext * c_ext;
    acc_sum  = acc + prod;
    rnd      = {acc_sum[ACC_W-1], acc_sum} + RND;
    shr      = rnd >>> SHIFT;
    res_data = shr[DATA_W-1:0];
    res_sat  = 1'b0;
    if (shr > MAX_V) begin
      res_data = MAX_V[DATA_W-1:0];
      res_sat  = 1'b1;
    end else if (shr < MIN_V) begin
      res_data = MIN_V[DATA_W-1:0];
      res_sat  = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = mode ? OUT : MAC;
      MAC:     if (tap == LAST_TAP) state_nx = OUT;
      OUT:     if (m_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      tap          <= '0;
      m_data       <= '0;
      m_sat        <= 1'b0;
      coef_err     <= 1'b0;
      sample_count <= '0;
      sat_count    <= '0;
      for (int k = 0; k < TAPS; k++) begin
        delay[k] <= '0;
        coeff[k] <= '0;
      end
    end else begin
      state    <= state_nx;
      coef_err <= coef_we && (state != IDLE);
      if (coef_we && state == IDLE) coeff[coef_addr] <= coef_data;
      case (state)
        IDLE: begin
          if (accept) begin
            for (int k = 1; k < TAPS; k++) delay[k] <= flush ? '0 : delay[k-1];
            delay[0] <= s_data;
            acc      <= '0;
            tap      <= '0;
            if (mode) begin
              m_data <= s_data;
              m_sat  <= 1'b0;
            end
          end else if (flush) begin
            for (int k = 0; k < TAPS; k++) delay[k] <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          tap <= tap + 1'b1;
          if (tap == LAST_TAP) begin
            m_data <= res_data;
            m_sat  <= res_sat;
          end
        end
        OUT: begin
          if (m_ready) begin
            sample_count <= sample_count + 32'd1;
            if (m_sat) sat_count <= sat_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
